// File: rtl/gpio_in_pkg.sv
// Shared constants and types for the GPIO input conditioning block.
// Channel order on the bus is {sw[15:0], btnC, btnU, btnL, btnR, btnD}.
package gpio_in_pkg;

    localparam int GPIO_IN_WIDTH         = 21;
    localparam int DEBOUNCE_TICK_DIV     = 100000;
    localparam int DEBOUNCE_STABLE_TICKS = 10;

    localparam int BTN_D    = 0;
    localparam int BTN_R    = 1;
    localparam int BTN_L    = 2;
    localparam int BTN_U    = 3;
    localparam int BTN_C    = 4;
    localparam int SW_LSB   = 5;
    localparam int SW_COUNT = 16;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

endpackage

// File: rtl/gpio_input_debounce_bit.sv
// One debounced channel: two-flop synchroniser, tick-based qualification
// counter and registered rise/fall pulses.
module debounce_bit
    import gpio_in_pkg::*;
#(
    parameter int   STABLE_TICKS = DEBOUNCE_STABLE_TICKS,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic din,
    input  logic tick,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic change
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync_meta_reg;
    logic          sync_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          dout_reg;
    logic          dout_next;
    logic          rise_reg;
    logic          fall_reg;
    edge_e         edge_next;

    // Any cycle where the synchronised pad agrees with the output restarts
    // qualification, so a glitch never carries partial credit forward.
    always_comb begin
        cnt_next  = cnt_reg;
        dout_next = dout_reg;
        edge_next = EDGE_NONE;
        if (sync_reg == dout_reg) begin
            cnt_next = '0;
        end else if (tick) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next  = '0;
                dout_next = sync_reg;
                edge_next = sync_reg ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync_meta_reg <= RESET_VAL;
            sync_reg      <= RESET_VAL;
            cnt_reg       <= '0;
            dout_reg      <= RESET_VAL;
            rise_reg      <= 1'b0;
            fall_reg      <= 1'b0;
        end else begin
            sync_meta_reg <= din;
            sync_reg      <= sync_meta_reg;
            cnt_reg       <= cnt_next;
            dout_reg      <= dout_next;
            rise_reg      <= (edge_next == EDGE_RISE);
            fall_reg      <= (edge_next == EDGE_FALL);
        end
    end

    assign dout = dout_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;
    // Unregistered so the parent's sticky mask lands on the same edge as the pulse.
    assign change = (edge_next != EDGE_NONE);

endmodule

// File: rtl/gpio_input_debounce.sv
// Debounces the board switches/buttons feeding the wrapper GPIO input and
// raises a sticky, acknowledgeable change interrupt.
module gpio_input_debounce
    import gpio_in_pkg::*;
#(
    parameter int               WIDTH        = GPIO_IN_WIDTH,
    parameter int               TICK_DIV     = DEBOUNCE_TICK_DIV,
    parameter int               STABLE_TICKS = DEBOUNCE_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] change_mask,
    output logic             irq,
    input  logic             irq_ack
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    prescale_reg;
    logic             tick;
    logic [WIDTH-1:0] change_vec;
    logic [WIDTH-1:0] change_mask_reg;
    logic             irq_reg;

    // Single prescaler shared by every channel.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            prescale_reg <= '0;
        end else if (prescale_reg == PRESCALE_LAST) begin
            prescale_reg <= '0;
        end else begin
            prescale_reg <= prescale_reg + 1'b1;
        end
    end

    assign tick = (prescale_reg == PRESCALE_LAST);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            debounce_bit #(
                .STABLE_TICKS(STABLE_TICKS),
                .RESET_VAL   (RESET_VAL[gi])
            ) u_bit (
                .sys_clk(sys_clk),
                .sys_rst(sys_rst),
                .din    (din[gi]),
                .tick   (tick),
                .dout   (dout[gi]),
                .rise   (rise[gi]),
                .fall   (fall[gi]),
                .change (change_vec[gi])
            );
        end
    endgenerate

    // A new edge in the ack cycle survives the clear.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            change_mask_reg <= '0;
            irq_reg         <= 1'b0;
        end else begin
            change_mask_reg <= (irq_ack ? '0 : change_mask_reg) | change_vec;
            irq_reg         <= |change_mask_reg;
        end
    end

    assign change_mask = change_mask_reg;
    assign irq         = irq_reg;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Randomised scenario bench for gpio_input_debounce against a tick-arithmetic
// reference model (TICK_DIV=4, STABLE_TICKS=3, RESET_VAL=0).
module tb_gpio_input_debounce;

    localparam int W = 21;
    localparam int D = 4;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         irq_ack;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] change_mask;
    logic         irq;

    gpio_input_debounce #(
        .WIDTH       (W),
        .TICK_DIV    (D),
        .STABLE_TICKS(S),
        .RESET_VAL   ({W{1'b0}})
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (rst_n),
        .din        (din),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .change_mask(change_mask),
        .irq        (irq),
        .irq_ack    (irq_ack)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: pad history, accepted levels, and for each channel the
    // cycle index at which its current disagreement began (-1 when none).
    logic [W-1:0] m_s1, m_s2, m_dout, m_rise, m_fall, m_cm;
    logic         m_irq;
    int           m_start [W];
    int           m_cyc;

    logic [4*W:0] obs;
    logic [4*W:0] expv;
    assign obs  = {dout, rise, fall, change_mask, irq};
    assign expv = {m_dout, m_rise, m_fall, m_cm, m_irq};

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_dout = '0; m_rise = '0; m_fall = '0;
        m_cm = '0; m_irq = 1'b0; m_cyc = 0;
        for (int b = 0; b < W; b++) m_start[b] = -1;
    endtask

    // Ticks fall on cycle indices c with c % D == D-1, so the ticks seen in
    // [start, c] are (c+1)/D - start/D; the level is accepted when that hits S.
    function automatic logic will_flip(int b);
        int st;
        if (m_s2[b] == m_dout[b]) return 1'b0;
        st = (m_start[b] >= 0) ? m_start[b] : m_cyc;
        return ((m_cyc + 1) / D - st / D) == S;
    endfunction

    task automatic step();
        logic [W-1:0] p_rise, p_fall, nd;
        @(posedge clk);
        if (rst_n) begin
            p_rise = '0; p_fall = '0; nd = m_dout;
            for (int b = 0; b < W; b++) begin
                if (m_s2[b] != m_dout[b]) begin
                    if (will_flip(b)) begin
                        nd[b] = m_s2[b];
                        p_rise[b] = m_s2[b];
                        p_fall[b] = ~m_s2[b];
                        m_start[b] = -1;
                    end else if (m_start[b] < 0) begin
                        m_start[b] = m_cyc;
                    end
                end else begin
                    m_start[b] = -1;
                end
            end
            m_irq  = |m_cm;
            m_cm   = (irq_ack ? '0 : m_cm) | p_rise | p_fall;
            m_dout = nd; m_rise = p_rise; m_fall = p_fall;
            m_s2 = m_s1; m_s1 = din;
            m_cyc++;
        end
        #1;
    endtask

    task automatic test_reset();
        int first_dout, first_irq, rise_cycles;
        din = '1; irq_ack = 1'b0; rst_n = 1'b0; model_reset();
        repeat (3) begin
            step();
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: outputs=%h required=0", obs);
            end
        end
        rst_n = 1'b1;
        first_dout = -1; first_irq = -1; rise_cycles = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL reset_release cyc %0d: observed %h required %h", i, obs, expv);
            end
            if (dout === '1 && first_dout < 0) first_dout = i;
            if (irq === 1'b1 && first_irq < 0) first_irq = i;
            if (rise === '1) rise_cycles++;
        end
        vectors++;
        if (first_dout < 1 || first_dout > 14) begin
            miscompares++;
            $display("FAIL reset_dout_latency: observed %0d required 1..14", first_dout);
        end
        vectors++;
        if (rise_cycles != 1) begin
            miscompares++;
            $display("FAIL reset_rise_width: observed %0d required 1", rise_cycles);
        end
        vectors++;
        if (change_mask !== '1) begin
            miscompares++;
            $display("FAIL reset_change_mask: observed %h required %h", change_mask, {W{1'b1}});
        end
        vectors++;
        if (first_irq != first_dout + 1) begin
            miscompares++;
            $display("FAIL reset_irq_delay: observed cyc %0d required %0d", first_irq, first_dout + 1);
        end
        din = '0;
        for (int i = 0; i < 16; i++) begin
            step();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL reset_settle cyc %0d: observed %h required %h", i, obs, expv);
            end
        end
        vectors++;
        if (dout !== '0) begin
            miscompares++;
            $display("FAIL reset_settle_dout: observed %h required 0", dout);
        end
        $display("test_reset: done, %0d vectors so far", vectors);
    endtask

    task automatic test_glitch();
        int pre;
        pre = int'($urandom_range(0, D - 1));
        for (int i = 0; i < pre + 23; i++) begin
            din[3] = (i >= pre && i < pre + 7);
            step();
            vectors++;
            if (obs !== expv || dout[3] !== 1'b0 || rise[3] !== 1'b0 || fall[3] !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch cyc %0d: observed %h required %h with bit3 quiet", i, obs, expv);
            end
        end
        $display("test_glitch: done, phase %0d", pre);
    endtask

    task automatic test_clean_press();
        int lat, width;
        for (int dir = 1; dir >= 0; dir--) begin
            din[0] = dir[0];
            lat = -1; width = 0;
            for (int i = 1; i <= 20; i++) begin
                step();
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL clean_press dir %0d cyc %0d: observed %h required %h", dir, i, obs, expv);
                end
                if ((dir == 1 ? rise[0] : fall[0]) === 1'b1) begin
                    width++;
                    if (lat < 0) lat = i;
                end
            end
            vectors++;
            if (lat < 11 || lat > 14 || dout[0] !== dir[0]) begin
                miscompares++;
                $display("FAIL clean_latency dir %0d: observed %0d required 11..14", dir, lat);
            end
            vectors++;
            if (width != 1) begin
                miscompares++;
                $display("FAIL clean_pulse_width dir %0d: observed %0d required 1", dir, width);
            end
        end
        $display("test_clean_press: done");
    endtask

    task automatic test_bounce();
        int rises, rise_at;
        rises = 0; rise_at = -1;
        for (int i = 0; i < 60; i++) begin
            din[7] = (i >= 40) ? 1'b1 : (((i / 5) % 2) == 0);
            step();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL bounce cyc %0d: observed %h required %h", i, obs, expv);
            end
            if (rise[7] === 1'b1) begin
                rises++;
                rise_at = i;
            end
        end
        vectors++;
        if (rises != 1 || rise_at < 40) begin
            miscompares++;
            $display("FAIL bounce_rise: observed %0d pulses last at %0d required 1 at >=40", rises, rise_at);
        end
        $display("test_bounce: done");
    endtask

    // The ack is sampled on the same edge that launches rise[2] and sets mask bit 2.
    task automatic test_ack_collision();
        logic acked;
        acked = 1'b0;
        din[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            irq_ack = will_flip(2);
            if (irq_ack) acked = 1'b1;
            step();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL ack_collision cyc %0d: observed %h required %h", i, obs, expv);
            end
            if (rise[2] === 1'b1) break;
        end
        irq_ack = 1'b0;
        vectors++;
        if (!acked || change_mask !== 21'h000004) begin
            miscompares++;
            $display("FAIL ack_collision_mask: observed %h required 000004", change_mask);
        end
        step();
        vectors++;
        if (irq !== 1'b1 || change_mask !== 21'h000004) begin
            miscompares++;
            $display("FAIL ack_collision_hold: observed irq=%b mask=%h required irq=1 mask=000004", irq, change_mask);
        end
        $display("test_ack_collision: done");
    endtask

    task automatic test_ack_plain();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        vectors++;
        if (change_mask !== '0 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_clear: observed mask=%h irq=%b required mask=0 irq=1", change_mask, irq);
        end
        step();
        vectors++;
        if (irq !== 1'b0 || obs !== expv) begin
            miscompares++;
            $display("FAIL ack_irq_drop: observed %h required %h", obs, expv);
        end
        $display("test_ack_plain: done");
    endtask

    task automatic test_reset_midqual();
        int rise_at;
        logic reached;
        reached = 1'b0;
        din[5] = 1'b1;
        for (int i = 0; i < 20 && !reached; i++) begin
            step();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL midqual_pre cyc %0d: observed %h required %h", i, obs, expv);
            end
            if (m_start[5] >= 0 && (m_cyc / D - m_start[5] / D) == 2) reached = 1'b1;
        end
        vectors++;
        if (!reached || dout[5] !== 1'b0) begin
            miscompares++;
            $display("FAIL midqual_two_ticks: observed reached=%b dout5=%b required reached=1 dout5=0", reached, dout[5]);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL midqual_async_reset: observed %h required 0", obs);
        end
        repeat (2) begin
            step();
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL midqual_reset_hold: observed %h required 0", obs);
            end
        end
        rst_n = 1'b1;
        rise_at = -1;
        for (int i = 1; i <= 16; i++) begin
            step();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL midqual_post cyc %0d: observed %h required %h", i, obs, expv);
            end
            if (rise[5] === 1'b1 && rise_at < 0) rise_at = i;
        end
        vectors++;
        if (rise_at != 12) begin
            miscompares++;
            $display("FAIL midqual_requalify: observed rise5 at %0d required 12", rise_at);
        end
        $display("test_reset_midqual: done");
    endtask

    task automatic test_random();
        int r, k;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                din = W'($urandom);
            end else if (r < 4) begin
                k = int'($urandom_range(0, W - 1));
                din[k] = ~din[k];
            end
            irq_ack = ($urandom_range(0, 19) == 0);
            step();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random cyc %0d: observed %h required %h", i, obs, expv);
            end
        end
        irq_ack = 1'b0;
        $display("test_random: done, %0d vectors so far", vectors);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_press();
        test_bounce();
        test_ack_collision();
        test_ack_plain();
        test_reset_midqual();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
